// File: rtl/store_buffer.sv
// Store path: reads len+1 words from internal SRAM and writes them to DRAM as one
// AXI INCR burst, replaying the whole burst on a non-OKAY write response.
module store_buffer #(
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_store_vld,
    input  logic [7:0]  ctrl_store_id,
    input  logic [11:0] ctrl_store_dram_addr,
    input  logic [7:0]  ctrl_store_len,
    input  logic [2:0]  ctrl_store_size,
    input  logic [7:0]  ctrl_store_st_addr,
    input  logic [1:0]  ctrl_store_sram_type,
    output logic        ctrl_store_rdy,
    output logic        store_sram_vld,
    output logic [7:0]  store_sram_addr,
    output logic [1:0]  store_sram_type,
    input  logic [31:0] sram_store_dout,
    output logic [7:0]  store_axi_awid,
    output logic [11:0] store_axi_awaddr,
    output logic [7:0]  store_axi_awlen,
    output logic [2:0]  store_axi_awsize,
    output logic [1:0]  store_axi_awburst,
    output logic        store_axi_awvld,
    input  logic        ctrl_dram_awrdy,
    output logic [31:0] store_axi_wdata,
    output logic [3:0]  store_axi_wstrb,
    output logic        store_axi_wlast,
    output logic        store_axi_wvld,
    input  logic        ctrl_dram_wrdy,
    input  logic [7:0]  ctrl_dram_bid,
    input  logic [1:0]  ctrl_dram_bresp,
    input  logic        ctrl_dram_bvld,
    output logic        store_axi_brdy,
    output logic        lsu_store_finished,
    output logic        lsu_store_err
);

    localparam logic [7:0] MAX_RETRY_C = 8'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t      state_reg;
    logic [7:0]  id_reg;
    logic [11:0] dram_addr_reg;
    logic [7:0]  len_reg;
    logic [2:0]  size_reg;
    logic [7:0]  st_addr_reg;
    logic [1:0]  type_reg;
    logic [7:0]  retry_cnt_reg;
    logic [8:0]  rd_cnt_reg;
    logic [8:0]  beat_cnt_reg;
    logic        finished_reg;
    logic        err_reg;

    logic [31:0] fifo_mem_reg [0:1];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  fifo_count_reg;
    logic        inflight_reg;

    logic        in_stream;
    logic        w_valid;
    logic        w_last;
    logic        w_pop;
    logic        rd_issue;
    logic [2:0]  occupancy;
    logic        accept;

    assign accept    = (state_reg == S_IDLE) && ctrl_store_vld;
    assign in_stream = (state_reg == S_ADDR) || (state_reg == S_DATA);
    assign w_valid   = (state_reg == S_DATA) && (fifo_count_reg != 2'd0);
    assign w_last    = w_valid && (beat_cnt_reg == {1'b0, len_reg});
    assign w_pop     = w_valid && ctrl_dram_wrdy;

    // Occupancy credits this cycle's pop so a 2-entry FIFO sustains one beat per cycle
    // without ever overflowing.
    assign occupancy = {1'b0, fifo_count_reg} + {2'b00, inflight_reg} - {2'b00, w_pop};
    assign rd_issue  = in_stream && (rd_cnt_reg <= {1'b0, len_reg}) && (occupancy < 3'd2);

    assign ctrl_store_rdy     = (state_reg == S_IDLE);
    assign store_sram_vld     = rd_issue;
    assign store_sram_addr    = st_addr_reg + rd_cnt_reg[7:0];
    assign store_sram_type    = type_reg;
    assign store_axi_awid     = id_reg;
    assign store_axi_awaddr   = dram_addr_reg;
    assign store_axi_awlen    = len_reg;
    assign store_axi_awsize   = size_reg;
    assign store_axi_awburst  = 2'b01;
    assign store_axi_awvld    = (state_reg == S_ADDR);
    assign store_axi_wdata    = fifo_mem_reg[rd_ptr_reg];
    assign store_axi_wstrb    = 4'hF;
    assign store_axi_wlast    = w_last;
    assign store_axi_wvld     = w_valid;
    assign store_axi_brdy     = (state_reg == S_RESP);
    assign lsu_store_finished = finished_reg;
    assign lsu_store_err      = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            id_reg        <= '0;
            dram_addr_reg <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            st_addr_reg   <= '0;
            type_reg      <= '0;
            retry_cnt_reg <= '0;
            rd_cnt_reg    <= '0;
            beat_cnt_reg  <= '0;
            finished_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            finished_reg <= 1'b0;
            err_reg      <= 1'b0;
            if (rd_issue) begin
                rd_cnt_reg <= rd_cnt_reg + 9'd1;
            end
            if (w_pop) begin
                beat_cnt_reg <= beat_cnt_reg + 9'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (ctrl_store_vld) begin
                        id_reg        <= ctrl_store_id;
                        dram_addr_reg <= ctrl_store_dram_addr;
                        len_reg       <= ctrl_store_len;
                        size_reg      <= ctrl_store_size;
                        st_addr_reg   <= ctrl_store_st_addr;
                        type_reg      <= ctrl_store_sram_type;
                        retry_cnt_reg <= '0;
                        rd_cnt_reg    <= '0;
                        beat_cnt_reg  <= '0;
                        state_reg     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ctrl_dram_awrdy) begin
                        state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_pop && w_last) begin
                        state_reg <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Responses carrying a foreign ID are consumed and dropped.
                    if (ctrl_dram_bvld && (ctrl_dram_bid == id_reg)) begin
                        if (ctrl_dram_bresp == 2'b00) begin
                            finished_reg <= 1'b1;
                            state_reg    <= S_IDLE;
                        end else if (retry_cnt_reg < MAX_RETRY_C) begin
                            retry_cnt_reg <= retry_cnt_reg + 8'd1;
                            rd_cnt_reg    <= '0;
                            beat_cnt_reg  <= '0;
                            state_reg     <= S_ADDR;
                        end else begin
                            finished_reg <= 1'b1;
                            err_reg      <= 1'b1;
                            state_reg    <= S_IDLE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem_reg[i] <= '0;
            end
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            fifo_count_reg <= '0;
            inflight_reg   <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (accept) begin
                wr_ptr_reg     <= 1'b0;
                rd_ptr_reg     <= 1'b0;
                fifo_count_reg <= '0;
            end else begin
                // SRAM data is valid the cycle after the read strobe.
                if (inflight_reg) begin
                    fifo_mem_reg[wr_ptr_reg] <= sram_store_dout;
                    wr_ptr_reg               <= ~wr_ptr_reg;
                end
                if (w_pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                fifo_count_reg <= fifo_count_reg + {1'b0, inflight_reg} - {1'b0, w_pop};
            end
        end
    end

endmodule
